// File: rtl/isp_pkg.sv
// Shared types and widths for the ISP stream sequencer and its token tracker.
package isp_pkg;
  localparam int ISP_PIPE_DEPTH = 28;
  localparam int PIX_W          = 72;
  localparam int CFG_W          = 36;
  localparam int COORD_W        = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // The lockstep pipeline may only step while a frame is feeding or draining.
  function automatic logic is_advancing(input seq_state_e s);
    return (s == ST_ACTIVE) || (s == ST_DRAIN);
  endfunction
endpackage

// File: rtl/isp_token_shift.sv
// Mirrors the pipeline with {valid, last} tokens so the sequencer knows what
// sits at the pipeline tail and how many real pixels are still in flight.
module isp_token_shift #(
  parameter int DEPTH = 28
) (
  input  logic clock,
  input  logic reset,
  input  logic advance,
  input  logic in_valid,
  input  logic in_last,
  output logic tail_valid,
  output logic tail_last,
  output logic empty
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign valid_d[0] = in_valid;
  assign last_d[0]  = in_last;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    assign valid_d[gi] = valid_q[gi-1];
    assign last_d[gi]  = last_q[gi-1];
  end

  // A token entering and a valid token leaving on the same advance cancel out.
  always_comb begin
    occ_d = occ_q;
    if (advance && in_valid && !valid_q[DEPTH-1]) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (advance && !in_valid && valid_q[DEPTH-1]) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      last_q  <= '0;
      occ_q   <= '0;
    end else begin
      if (advance) begin
        valid_q <= valid_d;
        last_q  <= last_d;
      end
      occ_q <= occ_d;
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_last  = last_q[DEPTH-1];
  assign empty      = (occ_q == '0);
endmodule

// File: rtl/isp_stream_sequencer.sv
// Frame controller owning the single advance enable of the lockstep ISP
// pipeline: feeds pixels or bubbles, drains at end of frame, applies config.
module isp_stream_sequencer
  import isp_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int PIPE_DEPTH = ISP_PIPE_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_wr,
  input  logic [CFG_W-1:0]   cfg_offset,
  input  logic [CFG_W-1:0]   cfg_gain,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_pixel,
  output logic               pipe_advance,
  output logic [PIX_W-1:0]   pipe_pixel,
  output logic [CFG_W-1:0]   pipe_offset,
  output logic [CFG_W-1:0]   pipe_gain,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               frame_done
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  seq_state_e         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CFG_W-1:0]   shadow_off_q, shadow_gain_q;
  logic [CFG_W-1:0]   live_off_q, live_gain_q;
  logic               out_free, accept, final_px, tok_empty;

  assign out_free = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign final_px = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ARM;
      ST_ARM:    state_d = ST_ACTIVE;
      ST_ACTIVE: if (accept && final_px) state_d = ST_DRAIN;
      // The last-marked pixel leaves after every earlier one, so its hand-off ends the frame.
      ST_DRAIN:  if ((m_valid && m_last && m_ready) || tok_empty) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    pipe_advance = out_free && is_advancing(state_q);
    s_ready      = pipe_advance && (state_q == ST_ACTIVE);
    frame_done   = (state_q == ST_DONE);
  end

  // The final accept leaves the counters parked on the last coordinate through DRAIN.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (state_q == ST_ARM) begin
      x_d = '0;
      y_d = '0;
    end else if (accept && !final_px) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      shadow_off_q  <= '0;
      shadow_gain_q <= '0;
      live_off_q    <= '0;
      live_gain_q   <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (cfg_wr) begin
        shadow_off_q  <= cfg_offset;
        shadow_gain_q <= cfg_gain;
      end
      if (state_q == ST_ARM) begin
        live_off_q  <= shadow_off_q;
        live_gain_q <= shadow_gain_q;
      end
    end
  end

  // During ARM the shadow is already presented so stages see the new frame's config at once.
  assign pipe_offset = (state_q == ST_ARM) ? shadow_off_q  : live_off_q;
  assign pipe_gain   = (state_q == ST_ARM) ? shadow_gain_q : live_gain_q;
  assign pipe_pixel  = accept ? s_pixel : '0;
  assign x_out       = x_q;
  assign y_out       = y_q;

  isp_token_shift #(
    .DEPTH(PIPE_DEPTH)
  ) u_tokens (
    .clock     (clock),
    .reset     (reset),
    .advance   (pipe_advance),
    .in_valid  (accept),
    .in_last   (accept && final_px),
    .tail_valid(m_valid),
    .tail_last (m_last),
    .empty     (tok_empty)
  );
endmodule

// File: tb/tb_isp_stream_sequencer.sv
// Directed bench for isp_stream_sequencer on a 4x2 frame through a 3-deep
// behavioural pipeline that stands in for the ISP stages.
module tb_isp_stream_sequencer;
  localparam int TB_W = 4;
  localparam int TB_H = 2;
  localparam int TB_D = 3;

  logic        clock, reset, start, cfg_wr;
  logic [35:0] cfg_offset, cfg_gain;
  logic        s_valid, s_ready;
  logic [71:0] s_pixel, pipe_pixel;
  logic        pipe_advance;
  logic [35:0] pipe_offset, pipe_gain;
  logic        m_valid, m_last, m_ready;
  logic [11:0] x_out, y_out;
  logic        busy, frame_done;

  isp_stream_sequencer #(
    .IMG_W(TB_W), .IMG_H(TB_H), .PIPE_DEPTH(TB_D)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_wr(cfg_wr),
    .cfg_offset(cfg_offset), .cfg_gain(cfg_gain),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .pipe_advance(pipe_advance), .pipe_pixel(pipe_pixel),
    .pipe_offset(pipe_offset), .pipe_gain(pipe_gain),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .x_out(x_out), .y_out(y_out), .busy(busy), .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural pipeline data path, stepped by the sampled advance enable
  logic        adv_s;
  logic [71:0] pix_s;
  logic [71:0] pm [TB_D];
  initial begin
    adv_s = 1'b0;
    pix_s = '0;
  end
  always @(posedge clock) begin
    if (adv_s) begin
      pm[0] <= pix_s;
      for (int i = 1; i < TB_D; i++) pm[i] <= pm[i-1];
    end
  end

  // Monitor: samples once per cycle, 2 time units after the falling edge
  int          clr_seq, clr_seen;
  int          cyc, n_acc, n_out, done_cnt, done_cyc, max_occ, pix_bad, first_acc, n_bub;
  bit          acc_log [512];
  bit          mv_log  [512];
  logic [71:0] out_pix [$];
  bit          out_last [$];
  int          out_cyc [$];

  initial begin
    clr_seq = 0;
    clr_seen = 0;
    cyc = 0; n_acc = 0; n_out = 0; done_cnt = 0; done_cyc = -1;
    max_occ = 0; pix_bad = 0; first_acc = -1; n_bub = 0;
  end

  always begin
    @(negedge clock);
    #2;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      cyc = 0; n_acc = 0; n_out = 0; done_cnt = 0; done_cyc = -1;
      max_occ = 0; pix_bad = 0; first_acc = -1; n_bub = 0;
      foreach (acc_log[i]) begin
        acc_log[i] = 1'b0;
        mv_log[i]  = 1'b0;
      end
      out_pix.delete();
      out_last.delete();
      out_cyc.delete();
    end
    if (n_acc - n_out > max_occ) max_occ = n_acc - n_out;
    adv_s = pipe_advance;
    pix_s = pipe_pixel;
    if (s_valid && s_ready) begin
      if (first_acc < 0) first_acc = cyc;
      n_acc++;
      if (pipe_pixel != s_pixel) pix_bad++;
      if (cyc < 512) acc_log[cyc] = 1'b1;
    end else if (pipe_advance && pipe_pixel != '0) begin
      pix_bad++;
    end
    if (s_ready && !s_valid) n_bub++;
    if (cyc < 512) mv_log[cyc] = m_valid;
    if (m_valid && m_ready) begin
      out_pix.push_back(pm[TB_D-1]);
      out_last.push_back(m_last);
      out_cyc.push_back(cyc);
      n_out++;
      $display("[%0t] cycle %0d out pixel=%0d last=%0b", $time, cyc, pm[TB_D-1], m_last);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("[%0t] cycle %0d frame_done", $time, cyc);
    end
    cyc++;
  end

  // Per-frame observations captured by the driver
  bit          sr_early, sr_at2, done_seen;
  int          bp_good;
  logic [35:0] arm_off, arm_gain, off_k8, gain_k8;
  logic [11:0] xk2, yk2, xk7, yk7, xk11, yk11;

  task automatic run_frame(input bit gaps, input bit stall, input bit mid_cfg,
                           input bit start_cfg, input bit mid_start, input logic [35:0] cfg_val);
    int k = 0;
    int next_pix = 1;
    int stall_left = 0;
    bit stall_used = 1'b0;
    logic [71:0] held = '0;
    done_seen = 1'b0;
    sr_early  = 1'b0;
    bp_good   = 0;
    while (!done_seen && k < 200) begin
      @(negedge clock);
      if (k == 0) clr_seq++;
      start      = (k == 0) || (mid_start && k == 6);
      cfg_wr     = (start_cfg && k == 0) || (mid_cfg && k == 4);
      cfg_offset = cfg_val;
      cfg_gain   = cfg_val + 36'd1;
      s_valid    = gaps ? (k % 2 == 1) : 1'b1;
      s_pixel    = 72'(next_pix);
      if (stall && !stall_used && m_valid && n_out == 2) begin
        stall_left = 5;
        stall_used = 1'b1;
        held       = pm[TB_D-1];
      end
      m_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        if (!pipe_advance && !s_ready && m_valid && !m_last && pm[TB_D-1] == held) bp_good++;
        stall_left--;
      end
      if (k < 2) sr_early = sr_early | s_ready;
      if (k == 1) begin arm_off = pipe_offset; arm_gain = pipe_gain; end
      if (k == 2) begin sr_at2 = s_ready; xk2 = x_out; yk2 = y_out; end
      if (k == 7) begin xk7 = x_out; yk7 = y_out; end
      if (k == 8) begin off_k8 = pipe_offset; gain_k8 = pipe_gain; end
      if (k == 11) begin xk11 = x_out; yk11 = y_out; end
      if (s_valid && s_ready) next_pix++;
      if (frame_done) done_seen = 1'b1;
      k++;
    end
    @(negedge clock);
    start = 1'b0; cfg_wr = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clock);
    check_val("frame_done_seen", 72'(done_seen), 72'(1));
  endtask

  task automatic verify_frame(input string tag);
    int lasts = 0;
    check_val({tag, "_out_count"}, 72'(out_pix.size()), 72'(8));
    for (int i = 0; i < out_pix.size() && i < 8; i++) begin
      check_val($sformatf("%s_pix%0d", tag, i), out_pix[i], 72'(i + 1));
      if (out_last[i]) lasts++;
    end
    check_val({tag, "_last_count"}, 72'(lasts), 72'(1));
    if (out_last.size() == 8) check_val({tag, "_last_on_8"}, 72'(out_last[7]), 72'(1));
    check_val({tag, "_done_pulses"}, 72'(done_cnt), 72'(1));
    check_val({tag, "_pixel_mux"}, 72'(pix_bad), 72'(0));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"},       72'(busy),         72'(0));
    check_val({tag, "_s_ready"},    72'(s_ready),      72'(0));
    check_val({tag, "_advance"},    72'(pipe_advance), 72'(0));
    check_val({tag, "_m_valid"},    72'(m_valid),      72'(0));
    check_val({tag, "_m_last"},     72'(m_last),       72'(0));
    check_val({tag, "_frame_done"}, 72'(frame_done),   72'(0));
    check_val({tag, "_x"},          72'(x_out),        72'(0));
    check_val({tag, "_y"},          72'(y_out),        72'(0));
    check_val({tag, "_offset"},     72'(pipe_offset),  72'(0));
    check_val({tag, "_gain"},       72'(pipe_gain),    72'(0));
    check_val({tag, "_pixel"},      pipe_pixel,        72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mis;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; start = 1'b0; cfg_wr = 1'b0; cfg_offset = '0; cfg_gain = '0;
    s_valid = 1'b0; s_pixel = '0; m_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1 check_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Basic frame: accepts on cycles 2..9, outputs on 5..12, frame_done on 13
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    verify_frame("basic");
    check_val("basic_sready_early", 72'(sr_early), 72'(0));
    check_val("basic_sready_at2", 72'(sr_at2), 72'(1));
    check_val("basic_first_accept", 72'(first_acc), 72'(2));
    if (out_cyc.size() == 8) begin
      check_val("basic_first_out_cyc", 72'(out_cyc[0]), 72'(5));
      check_val("basic_last_out_cyc", 72'(out_cyc[7]), 72'(12));
    end
    check_val("basic_done_cyc", 72'(done_cyc), 72'(13));
    check_val("basic_max_occ", 72'(max_occ), 72'(3));

    // Source gaps: alternating valid, output valid pattern = input delayed by 3
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    verify_frame("gaps");
    mis = 0;
    for (int c = 0; c + 3 < cyc && c + 3 < 512; c++)
      if (mv_log[c + 3] != acc_log[c]) mis++;
    check_val("gaps_delay3", 72'(mis), 72'(0));
    check_val("gaps_bubbles", 72'(n_bub), 72'(8));
    check_val("gaps_max_occ", 72'(max_occ), 72'(2));

    // Backpressure: 5 frozen cycles once two outputs have gone
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'h0);
    verify_frame("bp");
    check_val("bp_frozen_cycles", 72'(bp_good), 72'(5));

    // Config shadow: mid-frame write applies only at the next frame start
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 36'h10);
    check_val("cfg_cur_offset", 72'(off_k8), 72'(0));
    check_val("cfg_cur_gain", 72'(gain_k8), 72'(0));
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    check_val("cfg_arm_offset", 72'(arm_off), 72'(36'h10));
    check_val("cfg_arm_gain", 72'(arm_gain), 72'(36'h11));
    check_val("cfg_next_offset", 72'(off_k8), 72'(36'h10));
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 36'h20);
    check_val("cfg_same_cyc_arm", 72'(arm_off), 72'(36'h20));
    check_val("cfg_same_cyc_gain", 72'(arm_gain), 72'(36'h21));
    check_val("cfg_same_cyc_live", 72'(off_k8), 72'(36'h20));

    // Start while busy: ignored, counters continue, one frame_done
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 36'h0);
    verify_frame("busy_start");
    check_val("busy_start_x7", 72'(xk7), 72'(1));
    check_val("busy_start_y7", 72'(yk7), 72'(1));
    check_val("drain_x_hold", 72'(xk11), 72'(3));
    check_val("drain_y_hold", 72'(yk11), 72'(1));

    // Reset mid-frame with two tokens in flight
    @(negedge clock); start = 1'b1; s_valid = 1'b1; s_pixel = 72'd1; m_ready = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); s_pixel = 72'd1;
    @(negedge clock); s_pixel = 72'd2;
    @(negedge clock); s_valid = 1'b0;
    #1;
    check_val("pre_rst_x", 72'(x_out), 72'(2));
    check_val("pre_rst_offset", 72'(pipe_offset), 72'(36'h20));
    reset = 1'b0;
    #1 check_zero("midrst");
    @(negedge clock);
    reset = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0);
    verify_frame("after_rst");
    check_val("after_rst_x0", 72'(xk2), 72'(0));
    check_val("after_rst_y0", 72'(yk2), 72'(0));
    check_val("after_rst_shadow", 72'(arm_off), 72'(0));
    check_val("after_rst_first_acc", 72'(first_acc), 72'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/isp_stream_sequencer.md
# isp_stream_sequencer

Frame-level controller ahead of the lockstep ISP pipeline (BLC → LSC → DMSC → CCM → GAMMA). It owns the single advance enable that steps every stage at once. It accepts raw pixels over a valid/ready handshake and injects bubbles when no pixel is present. It tracks in-flight pixels with a token shift register, drains the pipeline at end of frame, and presents the results downstream with a `last` marker. Offset/gain configuration is double-buffered and applied only at frame start.

## Interface
Parameters:
- `IMG_W`, default 640: pixels per line (x range 0..IMG_W-1).
- `IMG_H`, default 480: lines per frame.
- `PIPE_DEPTH`, default 28: pipeline advances from input to `final_output` (BLC 4 + LSC 4 + DMSC 11 + CCM 6 + GAMMA 3).

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `start` in 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `cfg_wr` in 1: writes the shadow config.
- `cfg_offset` in 36: shadow offset data.
- `cfg_gain` in 36: shadow gain data.
- `s_valid` in 1: source pixel valid.
- `s_ready` out 1: source pixel accepted this cycle.
- `s_pixel` in 72: source pixel.
- `pipe_advance` out 1: drives `u_i_ready`/`u_r_ready` of every stage.
- `pipe_pixel` out 72: `input_pixel` of the pipeline.
- `pipe_offset` out 36: live offset, drives `offset_in`.
- `pipe_gain` out 36: live gain, drives `gain_in`.
- `m_valid` out 1: `final_output` holds a real pixel.
- `m_last` out 1: the valid output is the final pixel of the frame.
- `m_ready` in 1: downstream can accept.
- `x_out` out 12: x coordinate of the next pixel to accept.
- `y_out` out 12: y coordinate of the next pixel to accept.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse when the frame is complete.

## Operation
- States: IDLE, ARM, ACTIVE, DRAIN, DONE.
  - IDLE → ARM on `start`.
  - ARM (1 cycle): shadow config is copied to the live `pipe_offset`/`pipe_gain`, x and y are cleared; then → ACTIVE.
  - ACTIVE → DRAIN on acceptance of pixel (IMG_W-1, IMG_H-1).
  - DRAIN → DONE when token occupancy reaches 0 and `m_valid` has been consumed.
  - DONE (1 cycle, `frame_done`=1) → IDLE.
- `out_free = !m_valid | m_ready`.
- `pipe_advance = out_free & (state==ACTIVE | state==DRAIN)`.
- `s_ready = pipe_advance & state==ACTIVE`. Accept = `s_valid & s_ready`.
- `pipe_pixel = accept ? s_pixel : 72'd0`. When advancing without an accept, the cycle carries a bubble.
- Token shift register: PIPE_DEPTH entries of {valid, last}. On each `pipe_advance`, entry 0 ← {accept, accept & final pixel} and every other entry shifts by one. No shift occurs without an advance.
  - `m_valid`/`m_last` come from the tail entry.
  - The occupancy counter is +1 on accept, -1 on a valid tail consumed by a shift, unchanged when both happen in the same cycle.
- x/y counters: x increments on accept. At IMG_W-1, x wraps to 0 and y increments. They hold at their final values in DRAIN.
- `cfg_wr` is accepted in any state and updates the shadow only. A `cfg_wr` in the same cycle as `start` is the value that gets applied.
- `start` is ignored when `busy`=1.
- Reset mid-frame returns to IDLE and clears tokens, counters and the live config. Pixels still in the pipeline are discarded (`m_valid`=0).

## Timing
- Reset values: all outputs are 0, state is IDLE, occupancy is 0, shadow is 0.
- First `s_ready` is possible 2 cycles after the `start` pulse (IDLE→ARM→ACTIVE).
- Latency: a pixel accepted on advance k shows `m_valid`=1 after PIPE_DEPTH further advances. With no stalls, that is exactly PIPE_DEPTH cycles.
- Throughput: one pixel per cycle when `s_valid`=1 and `m_ready`=1 continuously.
- `m_ready`=0 with `m_valid`=1 freezes the entire pipeline, including input. `m_valid`, `m_last` and `final_output` are held stable.
- `frame_done` asserts in the cycle after the last valid output is consumed.

## Structure
- Shared package `isp_pkg`:
  - state enum;
  - `ISP_PIPE_DEPTH`=28;
  - pixel width 72 and config width 36;
  - coordinate width 12.
- Sub-module `isp_token_shift` holds the {valid, last} shift register and the occupancy counter. Its inputs are advance, in_valid and in_last; its outputs are tail_valid, tail_last and empty.

## Test plan
Parameters for all scenarios: IMG_W=4, IMG_H=2, PIPE_DEPTH=3.
- **Basic frame.** `start`, then `s_valid` held at 1 and `m_ready` held at 1, pixels 1..8.
  - `s_ready` goes high 2 cycles after `start`.
  - Outputs 1..8 appear in consecutive cycles starting 3 cycles after the first accept.
  - `m_last` is set only on output 8, and `frame_done` pulses once.
- **Source gaps.** `s_valid` toggles 1,0,1,0.
  - Bubbles are injected.
  - `m_valid` pattern at the output equals the input pattern delayed by 3.
  - Occupancy never exceeds 3.
- **Backpressure.** `m_ready`=0 for 5 cycles while `m_valid`=1.
  - `pipe_advance`=0 and `s_ready`=0 for those 5 cycles.
  - The output data is held.
  - No pixel is lost or duplicated.
- **Config shadow.** `cfg_wr` (offset 0x10) during ACTIVE.
  - `pipe_offset` is unchanged for the current frame.
  - It becomes 0x10 in the ARM cycle of the next `start`.
  - Also check `start` + `cfg_wr` (0x20) in the same cycle: 0x20 is applied.
- **Start while busy.** `start` pulsed mid-frame.
  - Ignored: counters continue.
  - Exactly one `frame_done`.
- **Reset mid-frame.** Drop `reset` with 2 tokens in flight.
  - All outputs go to 0 immediately.
  - After release, a fresh frame completes normally with x/y starting at 0.
